// File: rtl/rnn_pkg.sv
// Shared widths, fixed-point types and FSM encoding for the RNN mat-vec MAC block.
package rnn_pkg;
  localparam int DW        = 16;
  localparam int FRAC_BITS = 8;
  localparam int N_IN      = 4;
  localparam int N_OUT     = 32;

  localparam int ROW_W = $clog2(N_IN);
  localparam int COL_W = $clog2(N_OUT);
  localparam int PH_W  = $clog2(N_IN + 1);
  localparam int ACC_W = 2 * DW + $clog2(N_IN);

  typedef logic signed [DW-1:0]    fx_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OUT  = 2'd2
  } state_t;
endpackage

// File: rtl/rnn_mac_unit.sv
// Signed multiply-accumulate with clear, Q-format rescale and wrap (default) or
// saturation to DW bits when RNN_MAC_SAT_EN is defined.
module rnn_mac_unit
  import rnn_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  input  fx_t  i_x,
  input  fx_t  i_w,
  output fx_t  o_res
);

  acc_t                   r_acc;
  acc_t                   w_acc_next;
  logic signed [2*DW-1:0] w_prod;

`ifdef RNN_MAC_SAT_EN
  localparam acc_t SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam acc_t SAT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};
`endif

  function automatic fx_t fit(input acc_t a);
`ifdef RNN_MAC_SAT_EN
    if (a > SAT_MAX)      return {1'b0, {(DW-1){1'b1}}};
    else if (a < SAT_MIN) return {1'b1, {(DW-1){1'b0}}};
    else                  return a[DW-1:0];
`else
    return a[DW-1:0];
`endif
  endfunction

  assign w_prod = i_x * i_w;

  always_comb begin
    w_acc_next = r_acc;
    if (i_clr)
      w_acc_next = '0;
    else if (i_en)
      w_acc_next = r_acc + {{(ACC_W-2*DW){w_prod[2*DW-1]}}, w_prod};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_acc <= '0;
    else        r_acc <= w_acc_next;
  end

  // Result is taken from the next-state accumulator so the final product is
  // included when the top registers it on the RUN->OUT transition.
  assign o_res = fit(w_acc_next >>> FRAC_BITS);

endmodule

// File: rtl/rnn_matvec_mac.sv
// y = x * W over a 1-cycle-latency weight port, one column at a time, results
// streamed under valid/ready. Optional output saturation: RNN_MAC_SAT_EN.
module rnn_matvec_mac
  import rnn_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_IN*DW-1:0] in_x,
  output logic               w_rd_en,
  output logic [ROW_W-1:0]   w_row,
  output logic [COL_W-1:0]   w_col,
  input  logic [DW-1:0]      w_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DW-1:0]      out_data,
  output logic [COL_W-1:0]   out_idx,
  output logic               out_last,
  output logic               busy
);

  state_t           r_state;
  fx_t              r_x [N_IN];
  logic [COL_W-1:0] r_j;
  logic [PH_W-1:0]  r_c;
  logic             r_out_valid;
  logic [DW-1:0]    r_out_data;
  logic             r_out_last;

  logic             w_accept;
  logic             w_out_hs;
  logic             w_last_col;
  logic             w_last_ph;
  logic             w_mac_clr;
  logic             w_mac_en;
  logic [ROW_W-1:0] w_xsel;
  fx_t              w_res;

  assign w_accept   = (r_state == IDLE) && in_valid && rst_n;
  assign w_out_hs   = (r_state == OUT) && out_ready;
  assign w_last_col = (r_j == COL_W'(N_OUT - 1));
  assign w_last_ph  = (r_c == PH_W'(N_IN));
  assign w_mac_clr  = w_accept || (w_out_hs && !w_last_col);
  assign w_mac_en   = (r_state == RUN) && (r_c != '0);
  // Data read at phase c-1 arrives at phase c, so pair it with x[c-1].
  assign w_xsel     = r_c[ROW_W-1:0] - ROW_W'(1);

  assign in_ready  = rst_n && (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign w_rd_en   = (r_state == RUN) && (r_c < PH_W'(N_IN));
  assign w_row     = w_rd_en ? r_c[ROW_W-1:0] : '0;
  assign w_col     = w_rd_en ? r_j : '0;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_idx   = r_j;
  assign out_last  = r_out_last;

  rnn_mac_unit u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_mac_clr),
    .i_en  (w_mac_en),
    .i_x   (r_x[w_xsel]),
    .i_w   (w_rdata),
    .o_res (w_res)
  );

  always_ff @(posedge clk) begin
    if (w_accept)
      for (int i = 0; i < N_IN; i++) r_x[i] <= in_x[i*DW +: DW];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_j         <= '0;
      r_c         <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state <= RUN;
            r_j     <= '0;
            r_c     <= '0;
          end
        end
        RUN: begin
          if (w_last_ph) begin
            r_state     <= OUT;
            r_out_valid <= 1'b1;
            r_out_data  <= w_res;
            r_out_last  <= w_last_col;
          end else begin
            r_c <= r_c + PH_W'(1);
          end
        end
        OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            if (w_last_col) begin
              r_state <= IDLE;
            end else begin
              r_state <= RUN;
              r_j     <= r_j + COL_W'(1);
              r_c     <= '0;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rnn_matvec_mac.sv
// Directed self-checking bench for rnn_matvec_mac with a 1-cycle-latency weight ROM.
module tb_rnn_matvec_mac;
  import rnn_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [N_IN*DW-1:0] in_x;
  logic               w_rd_en;
  logic [ROW_W-1:0]   w_row;
  logic [COL_W-1:0]   w_col;
  logic [DW-1:0]      w_rdata = '0;
  logic               out_valid;
  logic               out_ready;
  logic [DW-1:0]      out_data;
  logic [COL_W-1:0]   out_idx;
  logic               out_last;
  logic               busy;

  int checks   = 0;
  int failures = 0;

  logic signed [15:0] wtab [4][32];
  int                 rom_mode = 0;

  logic [15:0] g_data [32];
  logic [4:0]  g_idx  [32];
  logic        g_last [32];
  int          n_out, first_cyc, last_cyc;

`ifdef RNN_MAC_SAT_EN
  localparam logic [15:0] EXP_OVF = 16'h7FFF;
`else
  localparam logic [15:0] EXP_OVF = 16'hFC00;
`endif

  localparam logic [63:0] X_BASIS = {16'h0000, 16'h0000, 16'h0000, 16'h0100};
  localparam logic [63:0] X_ONES  = {4{16'h0100}};
  localparam logic [63:0] X_MIX   = {16'hFF80, 16'h0200, 16'h0080, 16'hFE00};

  rnn_matvec_mac dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .w_rd_en(w_rd_en), .w_row(w_row), .w_col(w_col), .w_rdata(w_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] wval(input int r, input int c);
    if (rom_mode == 1) return 16'h7FFF;
    if (rom_mode == 2) return 16'h8001;
    return wtab[r][c];
  endfunction

  always @(posedge clk) if (w_rd_en) w_rdata <= wval(int'(w_row), int'(w_col));

  function automatic logic [15:0] model(input logic [63:0] x, input int j);
    longint acc = 0;
    longint r;
    logic signed [15:0] xs, ws;
    for (int i = 0; i < 4; i++) begin
      xs = x[i*16 +: 16];
      ws = wval(i, j);
      acc += longint'(xs) * longint'(ws);
    end
    r = acc >>> 8;
`ifdef RNN_MAC_SAT_EN
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
`endif
    return r[15:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_vec(input logic [63:0] x);
    @(negedge clk);
    chk("in_ready_before_start", 32'(in_ready), 32'd1);
    in_x = x;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Streams a whole vector with out_ready high; cycle numbers are counted in
  // clock edges after the input handshake edge.
  task automatic run_vec(input logic [63:0] x);
    int  cyc = 0;
    bit  done = 0;
    start_vec(x);
    n_out = 0;
    first_cyc = -1;
    while (!done && cyc < 1000) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (first_cyc < 0) first_cyc = cyc + 1;
        if (n_out < 32) begin
          g_data[n_out] = out_data;
          g_idx[n_out]  = out_idx;
          g_last[n_out] = out_last;
        end
        n_out++;
        if (out_last) done = 1;
      end
      @(posedge clk);
      cyc++;
    end
    last_cyc = cyc;
    #1;
    chk("vec_done_in_budget", 32'(done), 32'd1);
    chk("in_ready_after_last", 32'(in_ready), 32'd1);
  endtask

  task automatic check_vec(input logic [63:0] x, input string name);
    chk({name, "_count"}, 32'(n_out), 32'd32);
    for (int j = 0; j < 32; j++) begin
      chk($sformatf("%s_y[%0d]", name, j), 32'(g_data[j]), 32'(model(x, j)));
      chk($sformatf("%s_idx[%0d]", name, j), 32'(g_idx[j]), 32'(j));
      chk($sformatf("%s_last[%0d]", name, j), 32'(g_last[j]), 32'(j == 31));
    end
  endtask

  initial begin
    logic [15:0] bp_data;
    int          t;

    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 32; c++)
        wtab[r][c] = 16'((r + 1) * (c * 13 - 190));
    wtab[0][0]  = 16'h0016;
    wtab[0][7]  = 16'h0138;
    wtab[0][10] = 16'h0061;
    wtab[1][10] = 16'hFF94;
    wtab[2][10] = 16'hFF38;
    wtab[3][10] = 16'h0323;

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_x = '0;
    out_ready = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_w_rd_en", 32'(w_rd_en), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("idle_in_ready", 32'(in_ready), 32'd1);

    // Basis vector: y[j] = W[0][j]; also timing.
    run_vec(X_BASIS);
    check_vec(X_BASIS, "basis");
    chk("basis_y7_hand", 32'(g_data[7]), 32'h0138);
    chk("basis_y0_hand", 32'(g_data[0]), 32'h0016);
    chk("first_valid_cycle", 32'(first_cyc), 32'd6);
    chk("total_cycles", 32'(last_cyc), 32'd192);

    run_vec(X_ONES);
    check_vec(X_ONES, "ones");
    chk("ones_y10_hand", 32'(g_data[10]), 32'h0250);

    run_vec(X_MIX);
    check_vec(X_MIX, "mix");

    // Backpressure at j=3 with a stray in_valid while busy.
    start_vec(X_ONES);
    t = 0;
    while (!(out_idx == 5'd3 && !out_valid) && t < 500) begin @(negedge clk); t++; end
    chk("bp_reach_j3", 32'(t < 500), 32'd1);
    out_ready = 1'b0;
    t = 0;
    while (!out_valid && t < 50) begin @(negedge clk); t++; end
    chk("bp_valid_j3", 32'(out_valid), 32'd1);
    bp_data = out_data;
    chk("bp_data_j3", 32'(bp_data), 32'(model(X_ONES, 3)));
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_hold_valid_%0d", k), 32'(out_valid), 32'd1);
      chk($sformatf("bp_hold_data_%0d", k), 32'(out_data), 32'(bp_data));
      chk($sformatf("bp_hold_idx_%0d", k), 32'(out_idx), 32'd3);
      chk($sformatf("bp_no_read_%0d", k), 32'(w_rd_en), 32'd0);
      if (k == 2) begin
        in_x = X_MIX;
        in_valid = 1'b1;
        #1 chk("bp_in_ready_busy", 32'(in_ready), 32'd0);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    t = 0;
    while (!out_valid && t < 50) begin @(negedge clk); t++; end
    chk("bp_resume_idx", 32'(out_idx), 32'd4);
    chk("bp_resume_data", 32'(out_data), 32'(model(X_ONES, 4)));
    t = 0;
    while (!in_ready && t < 500) begin @(negedge clk); t++; end
    chk("bp_vec_done", 32'(in_ready), 32'd1);

    // Overflow: positive and mirrored negative*negative products.
    rom_mode = 1;
    run_vec({4{16'h7FFF}});
    chk("ovf_pos_y0", 32'(g_data[0]), 32'(EXP_OVF));
    chk("ovf_pos_y31", 32'(g_data[31]), 32'(EXP_OVF));
    rom_mode = 2;
    run_vec({4{16'h8001}});
    chk("ovf_mir_y0", 32'(g_data[0]), 32'(EXP_OVF));
    chk("ovf_mir_y31", 32'(g_data[31]), 32'(EXP_OVF));
    rom_mode = 0;

    // Asynchronous reset at j=12, c=2.
    start_vec(X_MIX);
    t = 0;
    while (!(out_idx == 5'd12 && w_rd_en && w_row == 2'd2) && t < 500) begin
      @(negedge clk); t++;
    end
    chk("mid_reach_j12_c2", 32'(t < 500), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_w_rd_en", 32'(w_rd_en), 32'd0);
    chk("mid_rst_w_row", 32'(w_row), 32'd0);
    chk("mid_rst_w_col", 32'(w_col), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_data", 32'(out_data), 32'd0);
    chk("mid_rst_out_idx", 32'(out_idx), 32'd0);
    chk("mid_rst_out_last", 32'(out_last), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    run_vec(X_ONES);
    chk("post_rst_y0", 32'(g_data[0]), 32'(model(X_ONES, 0)));
    check_vec(X_ONES, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
